// File: rtl/vid_rx_stat.sv
// Video stream monitor: measures width/height/checksum of each frame from a
// di/de/hs/vs stream and raises sticky flags on protocol violations.
module vid_rx_stat #(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  input  logic                   clr_i,
  output logic [CNT_WIDTH-1:0]   frame_w_o,
  output logic [CNT_WIDTH-1:0]   frame_h_o,
  output logic [31:0]            frame_sum_o,
  output logic [CNT_WIDTH-1:0]   frame_cnt_o,
  output logic                   frame_done_o,
  output logic                   err_line_len_o,
  output logic                   err_de_blank_o
);

  typedef enum logic [1:0] {WAIT_VS, H_BLANK, IN_LINE} state_t;

  state_t               state_q, state_d;
  logic                 vs_r_q, hs_r_q;
  logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0] ref_w_q, ref_w_d;
  logic [31:0]          sum_q, sum_d;
  logic [CNT_WIDTH-1:0] frame_w_q, frame_h_q, frame_cnt_q, frame_cnt_d;
  logic [31:0]          frame_sum_q;
  logic                 done_q, err_len_q, err_deb_q;

  logic vs_rise, vs_fall, hs_rise, hs_fall;
  logic active, start, accept, de_err;
  logic line_close, line_counted, first_line, len_err, frame_close;

  always_comb begin
    vs_rise = vs_i & ~vs_r_q;
    vs_fall = ~vs_i & vs_r_q;
    hs_fall = ~hs_i & hs_r_q;
    hs_rise = hs_i & ~hs_r_q;

    active      = (state_q != WAIT_VS);
    start       = (state_q == WAIT_VS) & vs_rise;
    accept      = de_i & ~hs_i & vs_i & (active | start);
    de_err      = de_i & (hs_i | ~vs_i) & active;

    line_close   = (state_q == IN_LINE) & (hs_rise | vs_fall);
    line_counted = line_close & (pix_cnt_q != '0);
    first_line   = (line_cnt_q == '0);
    len_err      = line_counted & ~first_line & (pix_cnt_q != ref_w_q);
    frame_close  = active & vs_fall;

    // Pixels can never be accepted on a closing edge (hs_i=1 or vs_i=0),
    // so clearing on close never drops a pixel.
    pix_cnt_d = pix_cnt_q;
    if (line_close || frame_close) pix_cnt_d = '0;
    else if (accept && !(&pix_cnt_q)) pix_cnt_d = pix_cnt_q + 1'b1;

    line_cnt_d = line_cnt_q;
    if (line_counted && !(&line_cnt_q)) line_cnt_d = line_cnt_q + 1'b1;

    ref_w_d = (line_counted && first_line) ? pix_cnt_q : ref_w_q;

    sum_d = sum_q + (accept ? 32'(di_i) : 32'd0);

    frame_cnt_d = clr_i ? '0 : frame_cnt_q;
    if (frame_close) frame_cnt_d = frame_cnt_d + 1'b1;

    state_d = state_q;
    case (state_q)
      WAIT_VS: if (vs_rise) state_d = hs_fall ? IN_LINE : H_BLANK;
      H_BLANK: if (vs_fall) state_d = WAIT_VS;
               else if (hs_fall && vs_i) state_d = IN_LINE;
      IN_LINE: if (vs_fall) state_d = WAIT_VS;
               else if (hs_rise) state_d = H_BLANK;
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_VS;
      vs_r_q      <= 1'b1;
      hs_r_q      <= 1'b1;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      ref_w_q     <= '0;
      sum_q       <= '0;
      frame_w_q   <= '0;
      frame_h_q   <= '0;
      frame_sum_q <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_deb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_r_q      <= vs_i;
      hs_r_q      <= hs_i;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= frame_close;
      // Set wins over a clear on the same edge.
      err_len_q   <= (err_len_q & ~clr_i) | len_err;
      err_deb_q   <= (err_deb_q & ~clr_i) | de_err;
      if (frame_close) begin
        frame_w_q   <= ref_w_d;
        frame_h_q   <= line_cnt_d;
        frame_sum_q <= sum_d;
        line_cnt_q  <= '0;
        ref_w_q     <= '0;
        sum_q       <= '0;
      end else begin
        line_cnt_q  <= line_cnt_d;
        ref_w_q     <= ref_w_d;
        sum_q       <= sum_d;
      end
    end
  end

  assign frame_w_o      = frame_w_q;
  assign frame_h_o      = frame_h_q;
  assign frame_sum_o    = frame_sum_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign frame_done_o   = done_q;
  assign err_line_len_o = err_len_q;
  assign err_de_blank_o = err_deb_q;

endmodule

// File: tb/tb_vid_rx_stat.sv
// Bench for vid_rx_stat: frames are described as lists of line lengths and the
// expected statistics are computed from those lists, then checked at frame_done.
module tb_vid_rx_stat;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  di_i = '0;
  logic        de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b0, clr_i = 1'b0;
  logic [15:0] frame_w_o, frame_h_o, frame_cnt_o;
  logic [31:0] frame_sum_o;
  logic        frame_done_o, err_line_len_o, err_de_blank_o;

  vid_rx_stat #(.PIXEL_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .di_i(di_i), .de_i(de_i), .hs_i(hs_i),
    .vs_i(vs_i), .clr_i(clr_i), .frame_w_o(frame_w_o), .frame_h_o(frame_h_o),
    .frame_sum_o(frame_sum_o), .frame_cnt_o(frame_cnt_o),
    .frame_done_o(frame_done_o), .err_line_len_o(err_line_len_o),
    .err_de_blank_o(err_de_blank_o));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int lens[8];
  bit          exp_pending = 0;
  logic [15:0] exp_w = 0, exp_h = 0, exp_cnt = 0;
  logic [31:0] exp_sum = 0;
  bit          exp_len_err = 0, exp_deb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Compare process: done must pulse exactly when a frame close is expected.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done", 32'(frame_done_o), 32'(exp_pending));
      if (exp_pending) begin
        chk("w", 32'(frame_w_o), 32'(exp_w));
        chk("h", 32'(frame_h_o), 32'(exp_h));
        chk("sum", frame_sum_o, exp_sum);
        chk("cnt", 32'(frame_cnt_o), 32'(exp_cnt));
        chk("err_len", 32'(err_line_len_o), 32'(exp_len_err));
        chk("err_deb", 32'(err_de_blank_o), 32'(exp_deb));
        exp_pending = 0;
      end
    end
  end

  task automatic send_frame(input int nl, input int gap, input bit rnd,
                            input bit same_edge, input int deb_line, input bit clr_close);
    int fw, fh, v;
    bit first, late_err;
    logic [31:0] s;
    fw = 0; fh = 0; first = 1; late_err = 0; s = 0;
    vs_i = 0; hs_i = 1; de_i = 0; step();
    vs_i = 1; step();
    for (int y = 0; y < nl; y++) begin
      hs_i = 0;
      if (lens[y] == 0) step();
      for (int x = 0; x < lens[y]; x++) begin
        v = rnd ? int'($urandom_range(0, 255)) : ((x + 8 * y) & 255);
        de_i = 1; di_i = 8'(v); s += 32'(v); step();
        de_i = 0; di_i = 0;
        repeat (gap) step();
      end
      if (lens[y] != 0) begin
        if (first) begin fw = lens[y]; first = 0; end
        else if (lens[y] != fw) begin
          if (y == nl - 1 && same_edge) late_err = 1;
          else exp_len_err = 1;
        end
        fh++;
      end
      hs_i = 1;
      if (y == nl - 1 && same_edge) begin vs_i = 0; clr_i = clr_close; end
      step();
      if (y == deb_line) begin
        de_i = 1; di_i = 8'hFF; step();
        de_i = 0; di_i = 0; exp_deb = 1;
      end
    end
    if (!(same_edge && nl > 0)) begin
      vs_i = 0; hs_i = 1; clr_i = clr_close; step();
    end
    clr_i = 0;
    if (clr_close) begin exp_cnt = 1; exp_len_err = late_err; exp_deb = 0; end
    else begin exp_cnt = exp_cnt + 1'b1; exp_len_err = exp_len_err | late_err; end
    exp_w = 16'(fw); exp_h = 16'(fh); exp_sum = s; exp_pending = 1;
    step();
  endtask

  task automatic do_clr();
    clr_i = 1; step(); clr_i = 0;
    exp_cnt = 0; exp_len_err = 0; exp_deb = 0;
    chk("clr_cnt", 32'(frame_cnt_o), 32'd0);
    chk("clr_errs", {30'd0, err_line_len_o, err_de_blank_o}, 32'd0);
  endtask

  task automatic set_lens(input int n, input int v);
    for (int i = 0; i < 8; i++) lens[i] = (i < n) ? v : 0;
  endtask

  initial begin
    int nl, base, dl;
    bit se;
    repeat (3) @(posedge clk); #1;
    chk("rst_w", 32'(frame_w_o), 0);
    chk("rst_h", 32'(frame_h_o), 0);
    chk("rst_sum", frame_sum_o, 0);
    chk("rst_cnt", 32'(frame_cnt_o), 0);
    chk("rst_flags", {29'd0, frame_done_o, err_line_len_o, err_de_blank_o}, 0);
    rst_n = 1; step();

    set_lens(4, 8);
    send_frame(4, 0, 0, 0, -1, 0);
    chk("pin_w", 32'(frame_w_o), 8);
    chk("pin_h", 32'(frame_h_o), 4);
    chk("pin_sum", frame_sum_o, 496);
    chk("pin_cnt", 32'(frame_cnt_o), 1);

    send_frame(4, 3, 0, 0, -1, 0);
    chk("pin_gap_sum", frame_sum_o, 496);

    lens[1] = 7;
    send_frame(4, 0, 0, 0, -1, 0);
    chk("pin_len_err", 32'(err_line_len_o), 1);
    chk("pin_short_sum", frame_sum_o, 481);
    chk("pin_short_w", 32'(frame_w_o), 8);
    do_clr();

    // Reset in the middle of frame A; the rest of A must not report.
    vs_i = 0; hs_i = 1; step();
    vs_i = 1; step();
    hs_i = 0;
    for (int x = 0; x < 8; x++) begin de_i = 1; di_i = 8'(x); step(); end
    de_i = 0; hs_i = 1; step();
    rst_n = 0; step(); step();
    chk("mid_rst_sum", frame_sum_o, 0);
    chk("mid_rst_cnt", 32'(frame_cnt_o), 0);
    exp_cnt = 0; exp_len_err = 0; exp_deb = 0;
    rst_n = 1;
    for (int y = 1; y < 4; y++) begin
      hs_i = 0;
      for (int x = 0; x < 8; x++) begin de_i = 1; di_i = 8'(x + 8 * y); step(); end
      de_i = 0; hs_i = 1; step();
    end
    vs_i = 0; step(); step();
    set_lens(4, 8);
    send_frame(4, 0, 0, 0, -1, 0);
    chk("pin_rst_cnt", 32'(frame_cnt_o), 1);
    chk("pin_rst_sum", frame_sum_o, 496);

    send_frame(4, 0, 0, 0, 1, 0);
    chk("pin_deb", 32'(err_de_blank_o), 1);
    chk("pin_deb_sum", frame_sum_o, 496);
    do_clr();

    send_frame(4, 0, 0, 1, -1, 0);
    send_frame(4, 0, 0, 1, -1, 0);
    chk("pin_b2b_h", 32'(frame_h_o), 4);
    chk("pin_b2b_cnt", 32'(frame_cnt_o), 2);

    send_frame(0, 0, 0, 0, -1, 0);
    chk("pin_empty_h", 32'(frame_h_o), 0);

    for (int f = 0; f < 30; f++) begin
      nl = int'($urandom_range(0, 5));
      base = int'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++)
        lens[i] = ($urandom_range(0, 3) != 0) ? base : int'($urandom_range(0, 9));
      se = (nl > 0) && ($urandom_range(0, 1) == 1);
      dl = (nl > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 2)) : -1;
      send_frame(nl, int'($urandom_range(0, 2)), 1, se, dl, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) do_clr();
    end

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vid_rx_stat.md
# vid_rx_stat

Synthesizable video stream receiver that consumes the same `di/de/hs/vs` pixel stream the scaler and its benches produce. It measures each frame's geometry: width, height, pixel checksum and frame count. It also flags protocol violations. It sits at a scaler output, or any video pipeline stage, as an on-chip monitor so the bench and hardware can compare frame statistics without capturing images.

## Interface
- `PIXEL_WIDTH`, 8: pixel data width.
- `CNT_WIDTH`, 16: width of the pixel, line and frame counters.
- `clk` in 1: single clock; all logic rises on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `di_i` in PIXEL_WIDTH: pixel data, valid when `de_i`=1.
- `de_i` in 1: pixel valid.
- `hs_i` in 1: horizontal blank, high between lines, low during an active line.
- `vs_i` in 1: frame active, high for the whole frame, low between frames.
- `clr_i` in 1: synchronous clear of the sticky errors and `frame_cnt_o`.
- `frame_w_o` out CNT_WIDTH: pixel count of the first line of the last completed frame.
- `frame_h_o` out CNT_WIDTH: line count of the last completed frame.
- `frame_sum_o` out 32: sum of all valid pixels of the last completed frame, mod 2^32.
- `frame_cnt_o` out CNT_WIDTH: number of completed frames.
- `frame_done_o` out 1: one-cycle pulse when the `frame_*` outputs update.
- `err_line_len_o` out 1: sticky; a line length differed from the frame's first line.
- `err_de_blank_o` out 1: sticky; `de_i` was asserted while `hs_i`=1 or `vs_i`=0.

## Operation
- Edge detection uses registers `vs_r` and `hs_r`. Both reset to 1, so a frame already in progress at reset release is not captured.
  - `vs_rise` = `vs_i & ~vs_r`; `vs_fall` = `~vs_i & vs_r`.
  - `hs_fall` = `~hs_i & hs_r`; `hs_rise` = `hs_i & ~hs_r`.
- FSM states:
  - `WAIT_VS` (reset state): ignore all input until `vs_rise`, then go to `H_BLANK`.
  - `H_BLANK`: on `hs_fall` with `vs_i`=1, go to `IN_LINE`. On `vs_fall`, close the frame and go to `WAIT_VS`.
  - `IN_LINE`: on `hs_rise`, close the line and go to `H_BLANK`. On `vs_fall`, close the line, then the frame, and go to `WAIT_VS`.
- Same-edge events:
  - `vs_rise` and `hs_fall` on the same edge go straight to `IN_LINE`.
  - A pixel with `de_i`=1 on the start edge is counted.
- Pixel acceptance: `de_i`=1, `hs_i`=0, `vs_i`=1, and state not `WAIT_VS` (including the start edge).
  - On acceptance: `pix_cnt` += 1, saturating at all-ones; `sum` += `di_i`, zero-extended, mod 2^32.
- `de_i`=1 with `hs_i`=1 or `vs_i`=0 in any state except `WAIT_VS`: set `err_de_blank_o`, ignore the pixel.
- Line close (`hs_rise`, or `vs_fall` while `IN_LINE`):
  - A line with `pix_cnt`=0 is not counted.
  - Otherwise `line_cnt` += 1, saturating.
  - If this is the first counted line, store `pix_cnt` as `ref_w`. Otherwise, if `pix_cnt` != `ref_w`, set `err_line_len_o`.
  - `pix_cnt` is cleared after every close.
- Frame close (`vs_fall`):
  - Latch `frame_w_o`=`ref_w`, `frame_h_o`=`line_cnt` (including a line closed on the same edge) and `frame_sum_o`=`sum` (including a pixel accepted on that edge, which cannot occur because `vs_i`=0).
  - `frame_cnt_o` += 1, wrapping.
  - Clear `line_cnt`, `sum`, `ref_w`.
- A frame with zero lines still closes: w=0, h=0, sum=0, done pulses.
- `clr_i`:
  - Clears `err_*` and `frame_cnt_o`.
  - If an error sets on the same edge, set wins.
  - If a frame closes on the same edge, `frame_cnt_o` becomes 1.
- Reset mid-frame: every output and internal register returns to its reset value immediately; the FSM goes to `WAIT_VS` and the partial frame is discarded.

## Timing
- Reset values: all outputs 0; `vs_r`=`hs_r`=1; FSM `WAIT_VS`.
- `frame_done_o` is high for exactly one cycle, the cycle after the edge that samples `vs_fall`. The `frame_*` outputs are valid in that same cycle and hold until the next frame close.
- Error flags assert the cycle after the violating edge.
- No backpressure: one pixel per cycle is accepted, and any number of gap cycles is allowed between pixels.
- Minimum blanking is 1 cycle for both `hs` and `vs`.

## Test plan
- 8x4 frame, no pixel gaps, pixel = x + 8y:
  - One `frame_done_o` pulse one cycle after `vs_i` falls.
  - w=8, h=4, sum=496, cnt=1, no errors.
- Same frame with 3 idle cycles per pixel (`de_i` sparse): identical results.
- Line 2 carries 7 pixels and the rest carry 8: `err_line_len_o`=1, w=8, h=4, sum reduced by the missing pixel.
- Reset asserted after line 1 of frame A, released mid-frame: no `frame_done_o` for frame A; the following full 8x4 frame reports w=8, h=4, sum=496, cnt=1.
- `de_i` pulse with `di_i`=0xFF during horizontal blank:
  - `err_de_blank_o`=1, sum still 496.
  - `clr_i` pulse then clears the error and cnt to 0.
- Two back-to-back frames where the last `hs_i` rise and the `vs_i` fall occur on the same edge: both frames report h=4, and cnt=2.
